// File: rtl/cafeteira_uc_multidose.sv
// Multi-dose coffee machine control unit: cup check, pump, heater and valve per dose,
// with internal heater/end timers, bounded cup retries and user abort.
module cafeteira_uc_multidose #(
  parameter int MAX_DOSES  = 4,
  parameter int DOSE_W     = 3,
  parameter int RETRY_MAX  = 3,
  parameter int T_INTERF   = 50,
  parameter int T_HEAT_MAX = 1000,
  parameter int T_FIM      = 200,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              preparar,
  input  logic              abortar,
  input  logic              pronto_serial,
  input  logic [DOSE_W-1:0] doses,
  input  logic              pronto_sensor_xicara,
  input  logic              tem_xicara,
  input  logic              timeout_xicara,
  input  logic              fim_bomba,
  input  logic              fim_temperatura,
  input  logic              fim_valvula,
  output logic              zera_sensor_xicara,
  output logic              zera_bomba,
  output logic              zera_valvula,
  output logic              zera_serial,
  output logic              zera_ebulidor,
  output logic              verifica_xicara,
  output logic              liga_bomba,
  output logic              ebulidor,
  output logic              liga_valvula,
  output logic              erro_sem_xicara,
  output logic              erro_timeout_ebulidor,
  output logic              erro_abortado,
  output logic              pronto,
  output logic [DOSE_W-1:0] dose_atual,
  output logic [4:0]        db_estado
);

  typedef enum logic [4:0] {
    S_INICIAL         = 5'b00000,
    S_PREPARA         = 5'b00001,
    S_ESPERA_MODO     = 5'b00011,
    S_PREP_XICARA     = 5'b01000,
    S_ATIVA_XICARA    = 5'b01001,
    S_ESPERA_XICARA   = 5'b01010,
    S_ERRO_XICARA     = 5'b01011,
    S_ATIVA_BOMBA     = 5'b01100,
    S_ESPERA_BOMBA    = 5'b01101,
    S_ATIVA_EBULIDOR  = 5'b01110,
    S_ESPERA_INTERF   = 5'b10100,
    S_ESPERA_EBULIDOR = 5'b10010,
    S_ERRO_EBULIDOR   = 5'b01111,
    S_ATIVA_VALVULA   = 5'b10000,
    S_ESPERA_VALVULA  = 5'b10011,
    S_PROX_DOSE       = 5'b10101,
    S_FIM             = 5'b10001,
    S_ABORTADO        = 5'b10110
  } state_t;

  localparam int                RW          = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RW-1:0]     RETRY_LIM   = RW'(RETRY_MAX);
  localparam logic [DOSE_W-1:0] MAX_D       = DOSE_W'(MAX_DOSES);
  localparam logic [CNT_W-1:0]  INTERF_LAST = CNT_W'(T_INTERF - 1);
  localparam logic [CNT_W-1:0]  HEAT_LAST   = CNT_W'(T_HEAT_MAX - 1);
  localparam logic [CNT_W-1:0]  FIM_LAST    = CNT_W'(T_FIM - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DOSE_W-1:0] dose_q, dose_d;
  logic [DOSE_W-1:0] target_q, target_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              abortable;

  assign abortable = !(state_q inside {S_INICIAL, S_PREPARA, S_ERRO_XICARA,
                                       S_ERRO_EBULIDOR, S_ABORTADO});

  always_comb begin
    state_d  = state_q;
    dose_d   = dose_q;
    target_d = target_q;
    retry_d  = retry_q;
    if (abortar && abortable) begin
      state_d = S_ABORTADO;
    end else begin
      case (state_q)
        S_INICIAL:      if (preparar) state_d = S_PREPARA;
        S_PREPARA:      state_d = S_ESPERA_MODO;
        S_ESPERA_MODO: begin
          if (pronto_serial) begin
            state_d = S_PREP_XICARA;
            dose_d  = DOSE_W'(1);
            retry_d = '0;
            if (doses == '0)        target_d = DOSE_W'(1);
            else if (doses > MAX_D) target_d = MAX_D;
            else                    target_d = doses;
          end
        end
        S_PREP_XICARA:  state_d = S_ATIVA_XICARA;
        S_ATIVA_XICARA: state_d = S_ESPERA_XICARA;
        S_ESPERA_XICARA: begin
          // A completed measurement outranks a simultaneous sensor timeout.
          if (pronto_sensor_xicara) begin
            state_d = tem_xicara ? S_ATIVA_BOMBA : S_ERRO_XICARA;
          end else if (timeout_xicara) begin
            if (retry_q == RETRY_LIM) begin
              state_d = S_ERRO_XICARA;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = S_PREP_XICARA;
            end
          end
        end
        S_ATIVA_BOMBA:    state_d = S_ESPERA_BOMBA;
        S_ESPERA_BOMBA:   if (fim_bomba) state_d = S_ATIVA_EBULIDOR;
        S_ATIVA_EBULIDOR: state_d = S_ESPERA_INTERF;
        S_ESPERA_INTERF:  if (cnt_q == INTERF_LAST) state_d = S_ESPERA_EBULIDOR;
        S_ESPERA_EBULIDOR: begin
          if (fim_temperatura)         state_d = S_ATIVA_VALVULA;
          else if (cnt_q == HEAT_LAST) state_d = S_ERRO_EBULIDOR;
        end
        S_ATIVA_VALVULA:  state_d = S_ESPERA_VALVULA;
        S_ESPERA_VALVULA: if (fim_valvula) state_d = S_PROX_DOSE;
        S_PROX_DOSE: begin
          if (dose_q == target_q) begin
            state_d = S_FIM;
          end else begin
            dose_d  = dose_q + 1'b1;
            retry_d = '0;
            state_d = S_PREP_XICARA;
          end
        end
        S_FIM:           if (cnt_q == FIM_LAST) state_d = S_INICIAL;
        S_ERRO_XICARA:   state_d = S_INICIAL;
        S_ERRO_EBULIDOR: state_d = S_INICIAL;
        S_ABORTADO:      state_d = S_INICIAL;
        default:         state_d = S_INICIAL;
      endcase
    end

    if (state_d == S_INICIAL) begin
      dose_d  = '0;
      retry_d = '0;
    end

    // One shared timer: restarts on every state change, runs only in timed states.
    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q inside {S_ESPERA_INTERF, S_ESPERA_EBULIDOR, S_FIM})
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  logic zera_all_d;
  assign zera_all_d = (state_d == S_INICIAL) || (state_d == S_PREPARA);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q               <= S_INICIAL;
      cnt_q                 <= '0;
      dose_q                <= '0;
      target_q              <= '0;
      retry_q               <= '0;
      zera_sensor_xicara    <= 1'b1;
      zera_bomba            <= 1'b1;
      zera_valvula          <= 1'b1;
      zera_serial           <= 1'b1;
      zera_ebulidor         <= 1'b1;
      verifica_xicara       <= 1'b0;
      liga_bomba            <= 1'b0;
      ebulidor              <= 1'b0;
      liga_valvula          <= 1'b0;
      erro_sem_xicara       <= 1'b0;
      erro_timeout_ebulidor <= 1'b0;
      erro_abortado         <= 1'b0;
      pronto                <= 1'b0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      dose_q                <= dose_d;
      target_q              <= target_d;
      retry_q               <= retry_d;
      zera_sensor_xicara    <= zera_all_d || (state_d == S_PREP_XICARA);
      zera_bomba            <= zera_all_d;
      zera_valvula          <= zera_all_d;
      zera_serial           <= zera_all_d;
      zera_ebulidor         <= zera_all_d;
      verifica_xicara       <= (state_d == S_ATIVA_XICARA);
      liga_bomba            <= (state_d == S_ATIVA_BOMBA);
      ebulidor              <= state_d inside {S_ATIVA_EBULIDOR, S_ESPERA_INTERF,
                                               S_ESPERA_EBULIDOR};
      liga_valvula          <= (state_d == S_ATIVA_VALVULA);
      erro_sem_xicara       <= (state_d == S_ERRO_XICARA);
      erro_timeout_ebulidor <= (state_d == S_ERRO_EBULIDOR);
      erro_abortado         <= (state_d == S_ABORTADO);
      pronto                <= (state_d == S_FIM);
    end
  end

  assign dose_atual = dose_q;
  assign db_estado  = state_q;

endmodule

// File: tb/tb_cafeteira_uc_multidose.sv
// Directed bench for cafeteira_uc_multidose: the bench plays the datapath and a
// per-order scoreboard compares pulse/cycle counts against a small behavioural model.
module tb_cafeteira_uc_multidose;

  localparam int MAX_DOSES  = 4;
  localparam int DOSE_W     = 3;
  localparam int RETRY_MAX  = 2;
  localparam int T_INTERF   = 4;
  localparam int T_HEAT_MAX = 10;
  localparam int T_FIM      = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic preparar = 0, abortar = 0, pronto_serial = 0;
  logic [DOSE_W-1:0] doses = '0;
  logic pronto_sensor_xicara = 0, tem_xicara = 0, timeout_xicara = 0;
  logic fim_bomba = 0, fim_temperatura = 0, fim_valvula = 0;
  logic zera_sensor_xicara, zera_bomba, zera_valvula, zera_serial, zera_ebulidor;
  logic verifica_xicara, liga_bomba, ebulidor, liga_valvula;
  logic erro_sem_xicara, erro_timeout_ebulidor, erro_abortado, pronto;
  logic [DOSE_W-1:0] dose_atual;
  logic [4:0] db_estado;

  int errors = 0;
  int checks = 0;

  cafeteira_uc_multidose #(
    .MAX_DOSES(MAX_DOSES), .DOSE_W(DOSE_W), .RETRY_MAX(RETRY_MAX),
    .T_INTERF(T_INTERF), .T_HEAT_MAX(T_HEAT_MAX), .T_FIM(T_FIM), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .preparar(preparar), .abortar(abortar),
    .pronto_serial(pronto_serial), .doses(doses),
    .pronto_sensor_xicara(pronto_sensor_xicara), .tem_xicara(tem_xicara),
    .timeout_xicara(timeout_xicara), .fim_bomba(fim_bomba),
    .fim_temperatura(fim_temperatura), .fim_valvula(fim_valvula),
    .zera_sensor_xicara(zera_sensor_xicara), .zera_bomba(zera_bomba),
    .zera_valvula(zera_valvula), .zera_serial(zera_serial),
    .zera_ebulidor(zera_ebulidor), .verifica_xicara(verifica_xicara),
    .liga_bomba(liga_bomba), .ebulidor(ebulidor), .liga_valvula(liga_valvula),
    .erro_sem_xicara(erro_sem_xicara), .erro_timeout_ebulidor(erro_timeout_ebulidor),
    .erro_abortado(erro_abortado), .pronto(pronto), .dose_atual(dose_atual),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int prep, verif, valv, ebul, heatw, pronto, err_x, err_e, err_a, steps, last;
  } exp_t;

  exp_t mon = '{default: 0};
  int   prev_dose = 0;
  exp_t sb_q[$];

  // Per-cycle activity counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (db_estado == 5'b01000) mon.prep++;
    if (verifica_xicara)       mon.verif++;
    if (liga_valvula)          mon.valv++;
    if (ebulidor)              mon.ebul++;
    if (db_estado == 5'b10010) mon.heatw++;
    if (pronto)                mon.pronto++;
    if (erro_sem_xicara)       mon.err_x++;
    if (erro_timeout_ebulidor) mon.err_e++;
    if (erro_abortado)         mon.err_a++;
    if (int'(dose_atual) == prev_dose + 1) mon.steps++;
    if (dose_atual != '0)      mon.last = int'(dose_atual);
    prev_dose = int'(dose_atual);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int d, input int tmo, input bit nocup,
                                 input int heat_at, input bit abort_i);
    exp_t e = '{default: 0};
    int n = (d == 0) ? 1 : ((d > MAX_DOSES) ? MAX_DOSES : d);
    e.steps = 1;
    e.last  = 1;
    if (abort_i) begin
      e.prep = 1; e.verif = 1; e.ebul = 2; e.err_a = 1;
    end else if (nocup) begin
      e.prep = 1; e.verif = 1; e.err_x = 1;
    end else if (tmo > RETRY_MAX) begin
      e.prep = RETRY_MAX + 1; e.verif = RETRY_MAX + 1; e.err_x = 1;
    end else if (heat_at == 0 || heat_at > T_HEAT_MAX) begin
      e.prep = 1; e.verif = 1; e.ebul = 1 + T_INTERF + T_HEAT_MAX;
      e.heatw = T_HEAT_MAX; e.err_e = 1;
    end else begin
      e.prep = n; e.verif = n; e.valv = n; e.ebul = n * (1 + T_INTERF + heat_at);
      e.heatw = n * heat_at; e.pronto = T_FIM; e.steps = n; e.last = n;
    end
    return e;
  endfunction

  task automatic clear_inputs();
    preparar = 0; abortar = 0; pronto_serial = 0; pronto_sensor_xicara = 0;
    tem_xicara = 0; timeout_xicara = 0; fim_bomba = 0; fim_temperatura = 0;
    fim_valvula = 0;
  endtask

  // Acts as ESP/serial/sensor/pump/valve until the FSM returns to inicial.
  task automatic serve(input int d, input int tmo, input bit nocup, input int heat_at,
                       input bit abort_i, input bit stop_bomba);
    int k = 0;
    int left = tmo;
    bit done = 0;
    logic [4:0] st;
    @(posedge clock); #2;
    preparar = 1;
    for (int s = 0; s < 400 && !done; s++) begin
      @(posedge clock); #2;
      clear_inputs();
      st = db_estado;
      k = (st == 5'b10010) ? k + 1 : 0;
      case (st)
        5'b00000: done = 1;
        5'b00011: begin pronto_serial = 1; doses = DOSE_W'(d); end
        5'b01010: begin
          if (left > 0) begin timeout_xicara = 1; left--; end
          else begin pronto_sensor_xicara = 1; tem_xicara = !nocup; end
        end
        5'b01101: if (stop_bomba) done = 1; else fim_bomba = 1;
        5'b10100: if (abort_i) abortar = 1;
        5'b10010: if (heat_at != 0 && k == heat_at) fim_temperatura = 1;
        5'b10011: fim_valvula = 1;
        5'b10110: begin
          chk("abort_ebulidor_low", int'(ebulidor), 0);
          chk("abort_pulse", int'(erro_abortado), 1);
        end
        5'b10001: preparar = 1;
        default: ;
      endcase
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL serve_timeout: observed state=%b expected return to 00000", db_estado);
    end
  endtask

  task automatic run_order(input string tag, input int d, input int tmo, input bit nocup,
                           input int heat_at, input bit abort_i);
    exp_t snap, e;
    sb_q.push_back(model(d, tmo, nocup, heat_at, abort_i));
    snap = mon;
    serve(d, tmo, nocup, heat_at, abort_i, 1'b0);
    @(negedge clock);
    e = sb_q.pop_front();
    chk({tag, ".prep"},   mon.prep   - snap.prep,   e.prep);
    chk({tag, ".verif"},  mon.verif  - snap.verif,  e.verif);
    chk({tag, ".valv"},   mon.valv   - snap.valv,   e.valv);
    chk({tag, ".ebul"},   mon.ebul   - snap.ebul,   e.ebul);
    chk({tag, ".heatw"},  mon.heatw  - snap.heatw,  e.heatw);
    chk({tag, ".pronto"}, mon.pronto - snap.pronto, e.pronto);
    chk({tag, ".err_x"},  mon.err_x  - snap.err_x,  e.err_x);
    chk({tag, ".err_e"},  mon.err_e  - snap.err_e,  e.err_e);
    chk({tag, ".err_a"},  mon.err_a  - snap.err_a,  e.err_a);
    chk({tag, ".steps"},  mon.steps  - snap.steps,  e.steps);
    chk({tag, ".last"},   mon.last,                 e.last);
    chk({tag, ".idle_state"}, int'(db_estado), 0);
    chk({tag, ".idle_dose"},  int'(dose_atual), 0);
  endtask

  initial begin
    clear_inputs();
    #12;
    chk("rst.state", int'(db_estado), 0);
    chk("rst.zera", int'({zera_sensor_xicara, zera_bomba, zera_valvula, zera_serial,
                          zera_ebulidor}), 31);
    chk("rst.others", int'({verifica_xicara, liga_bomba, ebulidor, liga_valvula,
                            erro_sem_xicara, erro_timeout_ebulidor, erro_abortado,
                            pronto}), 0);
    chk("rst.dose", int'(dose_atual), 0);
    @(posedge clock); #2;
    reset = 0;

    abortar = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #2;
      chk("abort_idle.state", int'(db_estado), 0);
      chk("abort_idle.pulse", int'(erro_abortado), 0);
    end
    abortar = 0;

    run_order("single",    1, 0, 0, 3, 0);
    run_order("three",     3, 0, 0, 3, 0);
    run_order("zero",      0, 0, 0, 3, 0);
    run_order("seven",     7, 0, 0, 3, 0);
    run_order("retries",   1, 3, 0, 3, 0);
    run_order("nocup",     1, 0, 1, 3, 0);
    run_order("heat_tmo",  1, 0, 0, 0, 0);
    run_order("heat_edge", 1, 0, 0, 10, 0);
    run_order("abort",     2, 0, 0, 3, 1);

    serve(2, 0, 0, 3, 0, 1'b1);
    chk("pre_reset.state", int'(db_estado), 5'b01101);
    #1 reset = 1;
    #1;
    chk("async_rst.state", int'(db_estado), 0);
    chk("async_rst.zera", int'({zera_sensor_xicara, zera_bomba, zera_valvula, zera_serial,
                                zera_ebulidor}), 31);
    chk("async_rst.others", int'({verifica_xicara, liga_bomba, ebulidor, liga_valvula,
                                  erro_sem_xicara, erro_timeout_ebulidor, erro_abortado,
                                  pronto}), 0);
    chk("async_rst.dose", int'(dose_atual), 0);
    @(posedge clock); #2;
    reset = 0;
    run_order("after_rst", 2, 0, 0, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cafeteira_uc_multidose.md
Name: cafeteira_uc_multidose

Overview:
- Next-generation coffee-machine control unit. Brews 1..MAX_DOSES cups per order, with per-dose cup checking and a bounded cup-sensor retry count.
- Generates its heater interference delay, heater timeout and end-hold timing with internal counters, so no external timers are needed for these.
- Adds an abort input. Sits between the ESP/serial front end and the pump, heater, valve and cup-sensor datapath.

Parameters:
- MAX_DOSES, 4, maximum doses per order.
- DOSE_W, 3, width of the doses input and of dose_atual.
- RETRY_MAX, 3, cup-sensor timeouts allowed per dose before erro_xicara.
- T_INTERF, 50, cycles the heater stays on before fim_temperatura is sampled.
- T_HEAT_MAX, 1000, heater timeout in cycles, counted in espera_ebulidor.
- T_FIM, 200, cycles the fim state is held.
- CNT_W, 16, width of the internal timer; must hold max(T_INTERF, T_HEAT_MAX, T_FIM).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- preparar  in  1  start order (ESP).
- abortar  in  1  user abort (ESP).
- pronto_serial  in  1  mode received; doses valid this cycle.
- doses  in  DOSE_W  requested cup count.
- pronto_sensor_xicara  in  1  cup measurement done.
- tem_xicara  in  1  cup present; valid with pronto_sensor_xicara.
- timeout_xicara  in  1  sensor gave no answer.
- fim_bomba  in  1  pump cycle done.
- fim_temperatura  in  1  water hot (ESP).
- fim_valvula  in  1  valve cycle done.
- zera_sensor_xicara, zera_bomba, zera_valvula, zera_serial, zera_ebulidor  out  1 each  datapath clears.
- verifica_xicara  out  1  trigger a cup measurement.
- liga_bomba  out  1  start pump.
- ebulidor  out  1  heater on.
- liga_valvula  out  1  start valve.
- erro_sem_xicara, erro_timeout_ebulidor, erro_abortado  out  1 each  one-cycle error pulses.
- pronto  out  1  order finished.
- dose_atual  out  DOSE_W  1-based index of the dose in progress; 0 when idle.
- db_estado  out  5  current state code.

Behaviour:
- Moore FSM. Outputs decode from the registered state only; no input-to-output combinational path.
- Reset: state = inicial, all counters = 0, dose_atual = 0. All outputs 0 except the five zera_* signals, which are 1.
- State codes:
  - inicial 00000, prepara 00001, espera_modo 00011.
  - prep_xicara 01000, ativa_xicara 01001, espera_xicara 01010, erro_xicara 01011.
  - ativa_bomba 01100, espera_bomba 01101.
  - ativa_ebulidor 01110, espera_interf 10100, espera_ebulidor 10010, erro_ebulidor 01111.
  - ativa_valvula 10000, espera_valvula 10011, prox_dose 10101, fim 10001, abortado 10110.
  - Unused codes go to inicial.
- Transitions:
  - inicial: preparar -> prepara.
  - prepara -> espera_modo.
  - espera_modo: pronto_serial -> prep_xicara. Latch dose target: 0 is treated as 1; values above MAX_DOSES are clamped to MAX_DOSES. dose_atual = 1.
  - prep_xicara -> ativa_xicara -> espera_xicara.
  - espera_xicara:
    - pronto_sensor_xicara with tem_xicara -> ativa_bomba.
    - pronto_sensor_xicara without tem_xicara -> erro_xicara.
    - Otherwise timeout_xicara: if retry count = RETRY_MAX -> erro_xicara; else retry count +1 -> prep_xicara.
    - pronto_sensor_xicara has priority over timeout_xicara.
  - ativa_bomba -> espera_bomba; fim_bomba -> ativa_ebulidor.
  - ativa_ebulidor -> espera_interf. Stays exactly T_INTERF cycles, then -> espera_ebulidor.
  - espera_ebulidor:
    - fim_temperatura -> ativa_valvula.
    - Otherwise, after T_HEAT_MAX cycles in the state -> erro_ebulidor.
    - fim_temperatura wins on the expiry cycle.
  - ativa_valvula -> espera_valvula; fim_valvula -> prox_dose.
  - prox_dose: if dose_atual = target -> fim; else dose_atual +1, retry count cleared -> prep_xicara.
  - fim: held exactly T_FIM cycles, then -> inicial. preparar is ignored while in fim.
  - erro_xicara, erro_ebulidor, abortado: one cycle each, then -> inicial.
- Abort:
  - abortar in any state other than inicial, prepara or the three one-cycle terminal states (erro_xicara, erro_ebulidor, abortado) -> abortado.
  - Abort has priority over every other transition.
  - The heater drops in the first abortado cycle.
- Outputs by state:
  - inicial/prepara: all zera_*.
  - prep_xicara: zera_sensor_xicara.
  - ativa_xicara: verifica_xicara.
  - ativa_bomba: liga_bomba.
  - ativa_ebulidor, espera_interf, espera_ebulidor: ebulidor.
  - ativa_valvula: liga_valvula.
  - erro_xicara: erro_sem_xicara.
  - erro_ebulidor: erro_timeout_ebulidor.
  - abortado: erro_abortado.
  - fim: pronto.
- Timer: a single counter, cleared on every state change and incremented while in espera_interf, espera_ebulidor or fim.
- dose_atual returns to 0 in inicial.
- Asynchronous reset mid-brew: heater and all other outputs drop immediately to their reset values.

Test Plan:
Test parameters for all scenarios: T_INTERF=4, T_HEAT_MAX=10, T_FIM=3, RETRY_MAX=2.
- Single dose, doses=1, cup present, fim_temperatura 2 cycles after espera_ebulidor -> ebulidor high for 1+4+3 cycles; one liga_valvula pulse; pronto high exactly 3 cycles; then inicial.
- doses=3 -> three full sequences; dose_atual steps 1, 2, 3; verifica_xicara pulses 3 times; single fim. doses=0 -> exactly one dose. doses=7 -> 4 doses.
- timeout_xicara three times in dose 1 -> two retries (prep_xicara re-entered twice), then erro_sem_xicara pulse and return to inicial. pronto_sensor_xicara with tem_xicara=0 -> immediate erro_sem_xicara.
- fim_temperatura never asserted -> erro_timeout_ebulidor after exactly 10 cycles in espera_ebulidor. fim_temperatura on the 10th cycle -> ativa_valvula instead of the error.
- abortar during espera_interf -> next state abortado, ebulidor=0, erro_abortado pulse, then inicial. abortar in inicial -> no effect.
- reset asserted during espera_bomba -> outputs go to reset values asynchronously; db_estado=00000; preparar then restarts the flow normally.
